// File: rtl/psum_pkg.sv
// psum_pkg
// Shared definitions for the partial-sum accumulation buffer:
//   - state_e       : run controller states (IDLE, RUN, DRAIN)
//   - PSUM_*        : default geometry (lanes, elements per lane, widths, depth)
//   - sat_clamps()  : 1 when a sign-extended sum falls outside the OUT_BIT range
//   - sat_relu()    : clamp to OUT_BIT range, then optionally zero negatives
package psum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int PSUM_X_PE       = 16;
    localparam int PSUM_LANE_ELEMS = 4;
    localparam int PSUM_IN_BIT     = 24;
    localparam int PSUM_ACC_BIT    = 32;
    localparam int PSUM_OUT_BIT    = 24;
    localparam int PSUM_DEPTH      = 1024;

    // Working width for the saturation helpers; callers sign-extend into it
    // and truncate the result back to OUT_BIT.
    localparam int SAT_W = 64;

    function automatic logic sat_clamps(input logic signed [SAT_W-1:0] v,
                                        input int out_bit);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_bit - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] v,
                                                         input int out_bit,
                                                         input logic relu);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (out_bit - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        if (relu && r[SAT_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_ram_sdp.sv
// psum_ram_sdp
// Simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address on the same edge returns the old
// contents; the parent handles that case with its own bypass.
//   clk       : clock
//   wr_en_i   : write enable
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read enable; rd_data_o holds its value while low
//   rd_addr_i : read address
//   rd_data_o : registered read data
module psum_ram_sdp #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer
// Accumulates PE result tiles over several input-channel passes in an
// on-chip circular buffer and emits saturated (optionally ReLU'd) tiles on
// the last pass.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_start           : pulse in IDLE latches cfg_* and starts a run
//   cfg_tiles/passes    : tiles per pass / passes per run (0 -> immediate done)
//   cfg_relu            : zero negative outputs
//   in_valid/ready/data : PE tile input, lane 0 at LSB
//   out_valid/ready/data: result tile output, held stable under backpressure
//   busy                : RUN or DRAIN
//   done                : one-cycle pulse after the final output is accepted
//   sat_flag            : sticky, some output element clamped this run
module psum_accum_buffer
    import psum_pkg::*;
#(
    parameter int X_PE       = PSUM_X_PE,
    parameter int LANE_ELEMS = PSUM_LANE_ELEMS,
    parameter int IN_BIT     = PSUM_IN_BIT,
    parameter int ACC_BIT    = PSUM_ACC_BIT,
    parameter int OUT_BIT    = PSUM_OUT_BIT,
    parameter int DEPTH      = PSUM_DEPTH,
    parameter int PTR_BIT    = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_start,
    input  logic [PTR_BIT:0]                   cfg_tiles,
    input  logic [7:0]                         cfg_passes,
    input  logic                               cfg_relu,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [X_PE*LANE_ELEMS*IN_BIT-1:0]  in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [X_PE*LANE_ELEMS*OUT_BIT-1:0] out_data,
    output logic                               busy,
    output logic                               done,
    output logic                               sat_flag
);

    localparam int ELEMS = X_PE * LANE_ELEMS;
    localparam int IN_W  = ELEMS * IN_BIT;
    localparam int ACC_W = ELEMS * ACC_BIT;
    localparam int OUT_W = ELEMS * OUT_BIT;

    // Run controller state
    state_e             state_q;
    logic [PTR_BIT:0]   cfg_tiles_q;
    logic [7:0]         cfg_passes_q;
    logic               cfg_relu_q;
    logic [PTR_BIT-1:0] tile_cnt_q;
    logic [7:0]         pass_cnt_q;
    logic               done_q;
    logic               sat_q;

    // Stage 1 (sum) registers
    logic               s1_valid_q;
    logic [IN_W-1:0]    s1_in_q;
    logic [PTR_BIT-1:0] s1_idx_q;
    logic               s1_first_q;
    logic               s1_last_q;
    logic               byp_sel_q;
    logic [ACC_W-1:0]   byp_data_q;

    // Output register
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;

    logic               adv1;
    logic               accept;
    logic               last_tile;
    logic               first_pass;
    logic               last_pass;
    logic               wr_en;
    logic               hazard;
    logic               out_load;
    logic [ACC_W-1:0]   rd_data;
    logic [ACC_W-1:0]   sum_w;
    logic [OUT_W-1:0]   out_next;
    logic [ELEMS-1:0]   sat_vec;

    // Stage 1 only stalls when it holds a last-pass tile that the output
    // register cannot take yet; non-last tiles always retire into the RAM.
    assign adv1       = !s1_valid_q || !s1_last_q || !out_valid_q || out_ready;
    assign in_ready   = (state_q == ST_RUN) && adv1;
    assign accept     = in_valid && in_ready;
    assign last_tile  = ({1'b0, tile_cnt_q} == (cfg_tiles_q - (PTR_BIT+1)'(1)));
    assign first_pass = (pass_cnt_q == 8'd0);
    assign last_pass  = (pass_cnt_q == (cfg_passes_q - 8'd1));
    assign wr_en      = s1_valid_q && !s1_last_q;
    // Read of the entry being written this edge would return stale data.
    assign hazard     = accept && wr_en && (s1_idx_q == tile_cnt_q);
    assign out_load   = s1_valid_q && s1_last_q && (!out_valid_q || out_ready);

    psum_ram_sdp #(
        .DEPTH (DEPTH),
        .WIDTH (ACC_W),
        .AW    (PTR_BIT)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (s1_idx_q),
        .wr_data_i (sum_w),
        .rd_en_i   (accept),
        .rd_addr_i (tile_cnt_q),
        .rd_data_o (rd_data)
    );

    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_elem
        logic signed [IN_BIT-1:0]  in_e;
        logic signed [ACC_BIT-1:0] base_e;
        logic signed [ACC_BIT-1:0] sum_e;
        logic signed [SAT_W-1:0]   wide_e;

        assign in_e   = s1_in_q[gi*IN_BIT +: IN_BIT];
        assign base_e = s1_first_q ? '0 :
                        (byp_sel_q ? byp_data_q[gi*ACC_BIT +: ACC_BIT]
                                   : rd_data[gi*ACC_BIT +: ACC_BIT]);
        assign sum_e  = base_e + ACC_BIT'(in_e);
        assign wide_e = SAT_W'(sum_e);
        assign sum_w[gi*ACC_BIT +: ACC_BIT]    = sum_e;
        assign sat_vec[gi]                     = sat_clamps(wide_e, OUT_BIT);
        assign out_next[gi*OUT_BIT +: OUT_BIT] = OUT_BIT'(sat_relu(wide_e, OUT_BIT, cfg_relu_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cfg_tiles_q  <= '0;
            cfg_passes_q <= '0;
            cfg_relu_q   <= 1'b0;
            tile_cnt_q   <= '0;
            pass_cnt_q   <= '0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_load && (|sat_vec)) begin
                sat_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        cfg_tiles_q  <= cfg_tiles;
                        cfg_passes_q <= cfg_passes;
                        cfg_relu_q   <= cfg_relu;
                        tile_cnt_q   <= '0;
                        pass_cnt_q   <= '0;
                        sat_q        <= 1'b0;
                        if ((cfg_tiles == '0) || (cfg_passes == 8'd0)) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last_tile) begin
                            tile_cnt_q <= '0;
                            if (last_pass) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                pass_cnt_q <= pass_cnt_q + 8'd1;
                            end
                        end else begin
                            tile_cnt_q <= tile_cnt_q + PTR_BIT'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid_q && (!out_valid_q || out_ready)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            byp_sel_q  <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_first_q <= first_pass;
                s1_last_q  <= last_pass;
                byp_sel_q  <= hazard;
            end
        end
    end

    // Stage 1 payload; loads only on accept, so it (and the RAM read data)
    // holds while stage 1 is stalled.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_in_q    <= in_data;
            s1_idx_q   <= tile_cnt_q;
            byp_data_q <= sum_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_next;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_psum_accum_buffer.sv
`timescale 1ns/1ps
module tb_psum_accum_buffer;

    localparam int X_PE       = 16;
    localparam int LANE_ELEMS = 4;
    localparam int IN_BIT     = 24;
    localparam int ACC_BIT    = 32;
    localparam int OUT_BIT    = 24;
    localparam int DEPTH      = 1024;
    localparam int PTR_BIT    = $clog2(DEPTH);
    localparam int ELEMS      = X_PE * LANE_ELEMS;
    localparam int IN_W       = ELEMS * IN_BIT;
    localparam int OUT_W      = ELEMS * OUT_BIT;
    localparam int MAXT       = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_start = 1'b0;
    logic [PTR_BIT:0]   cfg_tiles = '0;
    logic [7:0]         cfg_passes = '0;
    logic               cfg_relu = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [IN_W-1:0]    in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [OUT_W-1:0]   out_data;
    logic               busy;
    logic               done;
    logic               sat_flag;

    psum_accum_buffer #(
        .X_PE(X_PE), .LANE_ELEMS(LANE_ELEMS), .IN_BIT(IN_BIT),
        .ACC_BIT(ACC_BIT), .OUT_BIT(OUT_BIT), .DEPTH(DEPTH), .PTR_BIT(PTR_BIT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_tiles(cfg_tiles),
        .cfg_passes(cfg_passes), .cfg_relu(cfg_relu), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [OUT_BIT-1:0] v);
        logic signed [OUT_BIT-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    // Compares one whole tile, reporting the first differing element.
    task automatic chk_tile(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        int bad = -1;
        int idx;
        for (int e = 0; e < ELEMS; e++)
            if (bad < 0 && got[e*OUT_BIT +: OUT_BIT] !== exp[e*OUT_BIT +: OUT_BIT]) bad = e;
        idx = (bad < 0) ? 0 : bad;
        chk($sformatf("%s[%0d]", tag, idx), sx(got[idx*OUT_BIT +: OUT_BIT]), sx(exp[idx*OUT_BIT +: OUT_BIT]));
    endtask

    logic [OUT_W-1:0] exp_q[$];
    logic signed [31:0] acc_m [MAXT][ELEMS];
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_acc_cyc = 0;
    int  hold_req = 0;
    logic rand_ready = 1'b0;

    // out_ready driver
    initial forever begin
        @(negedge clk);
        if (hold_req > 0) begin
            out_ready = 1'b0;
            hold_req--;
        end else if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor / scoreboard
    initial begin
        logic [OUT_W-1:0] held;
        logic held_v = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (held_v) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk_tile("hold_stable", out_data, held);
            end
            held_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk_tile("out_data", out_data, exp_q.pop_front());
                $display("out tile accepted at cycle %0d elem0=%0d", cyc, sx(out_data[OUT_BIT-1:0]));
                last_acc_cyc = cyc;
            end else if (out_valid) begin
                held = out_data;
                held_v = 1'b1;
            end
        end
    end

    function automatic int stim_val(input int kind, input int p);
        case (kind)
            0: return (p + 1) * 10;
            1: return p + 1;
            2: return 'h600000;
            3: return (p == 0) ? -2 : -3;
            5: return (p == 0) ? 7 : 8;
            6: return -9;
            default: return int'($urandom_range(0, 2097151)) - 1048576;
        endcase
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sat", longint'(sat_flag), 0);
        chk_tile("rst_out_data", out_data, '0);
    endtask

    task automatic run(input int tiles, input int passes, input logic relu, input int kind,
                       input int abort_p, input int abort_t, input logic poke);
        int d0;
        int w;
        int v;
        logic exp_sat = 1'b0;
        logic signed [31:0] s;
        logic [OUT_W-1:0] et;
        d0 = done_cnt;
        @(negedge clk);
        cfg_start = 1'b1; cfg_tiles = (PTR_BIT+1)'(tiles); cfg_passes = 8'(passes); cfg_relu = relu;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int p = 0; p < passes; p++) begin
            for (int t = 0; t < tiles; t++) begin
                if (p == abort_p && t == abort_t) begin
                    in_valid = 1'b0;
                    rst = 1'b1;
                    @(negedge clk); #1;
                    chk_reset_outputs();
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    repeat (6) @(negedge clk);
                    #2 chk("abort_no_done", done_cnt - d0, 0);
                    $display("run aborted at pass %0d tile %0d", p, t);
                    return;
                end
                for (int e = 0; e < ELEMS; e++) begin
                    v = stim_val(kind, p);
                    in_data[e*IN_BIT +: IN_BIT] = IN_BIT'(v);
                    acc_m[t][e] = (p == 0) ? 32'(v) : acc_m[t][e] + 32'(v);
                end
                if (poke && p == 0 && t == 1) begin
                    cfg_start = 1'b1; cfg_tiles = 1; cfg_passes = 1;
                end
                if (kind == 4 && p == 1 && t == 2) hold_req = 5;
                in_valid = 1'b1;
                w = 0;
                #1;
                while (!in_ready && w < 200) begin
                    @(negedge clk); #1;
                    w++;
                end
                if (!in_ready) chk("in_ready_timeout", 0, 1);
                if (p == passes - 1) begin
                    for (int e = 0; e < ELEMS; e++) begin
                        s = acc_m[t][e];
                        if (s > 32'sd8388607) begin s = 32'sd8388607; exp_sat = 1'b1; end
                        else if (s < -32'sd8388608) begin s = -32'sd8388608; exp_sat = 1'b1; end
                        if (relu && s < 0) s = 0;
                        et[e*OUT_BIT +: OUT_BIT] = OUT_BIT'(s);
                    end
                    exp_q.push_back(et);
                end
                @(negedge clk);
                cfg_start = 1'b0;
                if (kind == 4 && $urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        w = 0;
        #2;
        while (done_cnt == d0 && w < 300) begin
            @(negedge clk); #2;
            w++;
        end
        chk("done_pulse", done_cnt - d0, 1);
        chk("done_latency", done_cyc - last_acc_cyc, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("sat_flag", longint'(sat_flag), longint'(exp_sat));
        chk("busy_idle", longint'(busy), 0);
        repeat (3) @(negedge clk);
        #2 chk("single_done", done_cnt - d0, 1);
        $display("run tiles=%0d passes=%0d relu=%0d kind=%0d complete", tiles, passes, relu, kind);
    endtask

    task automatic zero_cfg(input int tiles, input int passes);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        cfg_start = 1'b1; cfg_tiles = (PTR_BIT+1)'(tiles); cfg_passes = 8'(passes);
        @(negedge clk);
        cfg_start = 1'b0;
        #2;
        chk("zero_done", longint'(done), 1);
        chk("zero_busy", longint'(busy), 0);
        repeat (4) @(negedge clk);
        #2;
        chk("zero_single_done", done_cnt - d0, 1);
        chk("zero_no_out", longint'(out_valid), 0);
        $display("zero config tiles=%0d passes=%0d complete", tiles, passes);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        run(4, 3, 1'b0, 0, -1, -1, 1'b0);
        run(1, 4, 1'b0, 1, -1, -1, 1'b0);
        run(1, 2, 1'b0, 2, -1, -1, 1'b0);
        run(1, 2, 1'b1, 3, -1, -1, 1'b0);
        rand_ready = 1'b1;
        run(8, 2, 1'b0, 4, -1, -1, 1'b0);
        rand_ready = 1'b0;
        run(4, 3, 1'b0, 0, 1, 3, 1'b0);
        run(2, 2, 1'b0, 5, -1, -1, 1'b0);
        run(2, 2, 1'b0, 5, -1, -1, 1'b1);
        zero_cfg(2, 0);
        zero_cfg(0, 3);
        run(1, 1, 1'b0, 6, -1, -1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_accum_buffer.md
Name: psum_accum_buffer

Overview:
Parametrised successor to the fixed inter-pass FIFO path of the Winograd PE core. It sits between the X_PE Winograd PE result lanes and the pool stage. It accumulates RESULT_SIZE x RESULT_SIZE output tiles across a configurable number of input-channel passes in an on-chip circular buffer of configurable depth. On the last pass it emits saturated results, with optional ReLU, under a valid/ready handshake.

Parameters:
X_PE, 16, number of parallel PE lanes
LANE_ELEMS, 4, elements per lane per tile (RESULT_SIZE squared)
IN_BIT, 24, signed width of each incoming PE result element
ACC_BIT, 32, signed accumulator and buffer element width (must be >= IN_BIT)
OUT_BIT, 24, signed output element width (must be <= ACC_BIT)
DEPTH, 1024, tiles held per pass (buffer entries)
PTR_BIT, clog2(DEPTH), tile pointer width

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and begins a run
cfg_tiles  in  PTR_BIT+1  tiles per pass, 1..DEPTH
cfg_passes  in  8  passes per run, 1..255
cfg_relu  in  1  clamp negative outputs to 0
in_valid  in  1  PE tile valid
in_ready  out  1  tile accepted when in_valid && in_ready
in_data  in  X_PE*LANE_ELEMS*IN_BIT  PE tile results, lane 0 at LSB
out_valid  out  1  result tile valid
out_ready  in  1  downstream accepts
out_data  out  X_PE*LANE_ELEMS*OUT_BIT  final results
busy  out  1  run in progress
done  out  1  one-cycle pulse after the final output is accepted
sat_flag  out  1  sticky; some output element saturated this run

Behaviour:
- One clock; reset is synchronous and active-high.
- While rst is high, all outputs are 0 and the state is IDLE. Buffer contents need no reset because pass 0 overwrites them.
- A rst mid-run abandons the run. No done pulse is produced, and sat_flag clears.
- States:
  - IDLE: in_ready=0. cfg_start moves to RUN, latches cfg_*, clears tile_cnt, pass_cnt and sat_flag. cfg_start with cfg_tiles=0 or cfg_passes=0 produces done the next cycle and stays in IDLE. cfg_start outside IDLE is ignored.
  - RUN: accepts tiles. tile_cnt increments per accept and wraps to 0 after cfg_tiles-1, at which point pass_cnt increments. Accepting the last tile of the last pass moves to DRAIN.
  - DRAIN: in_ready=0. Waits until stage 1 is empty and out_valid=0 (or the last output is being accepted), then pulses done and returns to IDLE.
- busy=1 in RUN and DRAIN.
- Pipeline, for an accept at edge n:
  - Stage 0: buffer read of entry tile_cnt is issued at edge n. in_data, tile index, first/last flags go into stage 1.
  - Stage 1 (cycle n+1): sum = sign_ext(in) if pass 0, else buf_rd + sign_ext(in), computed in ACC_BIT with two's-complement wrap.
  - At edge n+1, non-last passes write sum to the buffer. The last pass loads the out register, so out_valid rises after edge n+1.
- Throughput is one tile per cycle.
- Hazard bypass: if stage 1 writes entry t at the same edge stage 0 reads entry t (only possible when cfg_tiles=1), stage 1 of the next tile uses the forwarded sum, not the RAM output.
- Output, per element: sat = clamp(sum, -2^(OUT_BIT-1), 2^(OUT_BIT-1)-1); ReLU is then applied if cfg_relu. Any clamp sets sat_flag.
- Backpressure:
  - adv1 = !s1_valid || !s1_last || !out_valid || out_ready.
  - in_ready = (state==RUN) && adv1.
  - The stage 1 register holds while !adv1, and the RAM read data is held alongside it.
  - out_data stays stable while out_valid && !out_ready. No tile is dropped or duplicated.
- cfg_passes=1: each output is sat(in), and no buffer write occurs.

Decomposition:
- Package psum_pkg: state encoding (IDLE, RUN, DRAIN), the lane/element slicing constants, and the saturate+ReLU function.
- One natural sub-module, psum_ram_sdp: simple dual-port RAM with synchronous read, DEPTH x (X_PE*LANE_ELEMS*ACC_BIT), one write port and one read port. The hazard bypass lives in the parent, not the RAM.

Test Plan:
1. tiles=4, passes=3, every element 10/20/30 in passes 0/1/2, out_ready=1 -> 4 outputs, all elements 60, in tile order; done one cycle after the 4th accept; sat_flag=0.
2. tiles=1, passes=4, back-to-back elements 1,2,3,4 (bypass path) -> single output of 10 two cycles after the 4th accept.
3. OUT_BIT=24, passes=2, elements 0x600000 twice -> 0x7FFFFF with sat_flag=1. Separately, cfg_relu=1 with a -5 sum -> 0 and sat_flag=0.
4. tiles=8, passes=2, out_ready toggled randomly and held low for 5 cycles -> in_ready drops within the cycle, out_data stays stable, all 8 results correct and in order.
5. rst asserted at pass 1, tile 3 of a 3-pass run, then a new run tiles=2, passes=2 with values 7,8 -> outputs 15, no done from the aborted run, outputs 0 during reset.
6. cfg_start during RUN is ignored; cfg_passes=0 -> done the next cycle with no output; passes=1 with -9 -> -9.
